// File: rtl/wb_arbiter_if.sv
// Bundle between the three result sources, wb_arbiter and the two register-file write ports.
interface wb_arbiter_if;
    logic [2:0]  src_valid;
    logic [2:0]  src_ready;
    logic [17:0] src_addr;
    logic [95:0] src_data;
    logic        we1;
    logic [5:0]  aw1;
    logic [31:0] wd1;
    logic        we2;
    logic [5:0]  aw2;
    logic [31:0] wd2;
    logic [3:0]  pending;

    modport master (
        output src_valid, src_addr, src_data,
        input  src_ready, we1, aw1, wd1, we2, aw2, wd2, pending
    );

    modport slave (
        input  src_valid, src_addr, src_data,
        output src_ready, we1, aw1, wd1, we2, aw2, wd2, pending
    );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: buffers results from ALU, FPU and load unit in per-source FIFOs
// and issues up to two register-file writes per cycle with round-robin fairness.
module wb_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    wb_arbiter_if.slave bus
);
    localparam int PW = (DEPTH > 2) ? 2 : 1;
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
    } entry_t;

    entry_t        mem_q  [3][DEPTH];
    logic [PW-1:0] wptr_q [3];
    logic [PW-1:0] rptr_q [3];
    logic [CW-1:0] cnt_q  [3];
    logic [CW-1:0] cnt_d  [3];
    entry_t        head   [3];
    logic [2:0]    ready, push, pop;
    logic [1:0]    rr_q, rr_d, s1, s2, idx;
    logic          g1, g2, c2;
    logic [3:0]    pend_q, pend_d;
    logic          we1_q, we2_q;
    logic [5:0]    aw1_q, aw2_q;
    logic [31:0]   wd1_q, wd2_q;

    function automatic logic [1:0] inc3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            head[i]  = mem_q[i][rptr_q[i]];
            ready[i] = cnt_q[i] < CNT_FULL;
        end
        push = bus.src_valid & ready;
    end

    always_comb begin
        // NOTE: every variable driven here is defaulted first, so no path can infer a latch.
        g1  = 1'b0;
        c2  = 1'b0;
        s1  = rr_q;
        s2  = rr_q;
        idx = rr_q;
        pop = '0;
        for (int k = 0; k < 3; k++) begin
            if (cnt_q[idx] != '0) begin
                if (!g1) begin
                    g1 = 1'b1;
                    s1 = idx;
                end else if (!c2) begin
                    c2 = 1'b1;
                    s2 = idx;
                end
            end
            idx = inc3(idx);
        end
        // A port-2 candidate writing the same register as port 1 waits at its head.
        g2 = c2 && (head[s2].addr != head[s1].addr);
        if (g1) pop[s1] = 1'b1;
        if (g2) pop[s2] = 1'b1;
        rr_d = g2 ? inc3(s2) : (g1 ? inc3(s1) : rr_q);
    end

    always_comb begin
        pend_d = '0;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = cnt_q[i];
            if (push[i] && !pop[i])      cnt_d[i] = cnt_q[i] + CW'(1);
            else if (!push[i] && pop[i]) cnt_d[i] = cnt_q[i] - CW'(1);
            pend_d = pend_d + 4'(cnt_d[i]);
        end
    end

    // NOTE: entry storage carries no reset; counts and pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (push[i] && !rst) mem_q[i][wptr_q[i]] <= {bus.src_addr[6*i +: 6], bus.src_data[32*i +: 32]};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                cnt_q[i]  <= '0;
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
            end
            rr_q   <= '0;
            pend_q <= '0;
            we1_q  <= 1'b0;
            we2_q  <= 1'b0;
            aw1_q  <= '0;
            aw2_q  <= '0;
            wd1_q  <= '0;
            wd2_q  <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
                if (push[i]) wptr_q[i] <= (wptr_q[i] == PTR_LAST) ? '0 : wptr_q[i] + PW'(1);
                if (pop[i])  rptr_q[i] <= (rptr_q[i] == PTR_LAST) ? '0 : rptr_q[i] + PW'(1);
            end
            rr_q   <= rr_d;
            pend_q <= pend_d;
            // Register 0 is never written, but a head targeting it still consumes its grant.
            we1_q  <= g1 && (head[s1].addr != '0);
            we2_q  <= g2 && (head[s2].addr != '0);
            if (g1) begin
                aw1_q <= head[s1].addr;
                wd1_q <= head[s1].data;
            end
            if (g2) begin
                aw2_q <= head[s2].addr;
                wd2_q <= head[s2].data;
            end
        end
    end

    assign bus.src_ready = ready;
    assign bus.we1       = we1_q;
    assign bus.aw1       = aw1_q;
    assign bus.wd1       = wd1_q;
    assign bus.we2       = we2_q;
    assign bus.aw2       = aw2_q;
    assign bus.wd2       = wd2_q;
    assign bus.pending   = pend_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (DEPTH = 2).
module tb_wb_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    wb_arbiter_if bus ();

    wb_arbiter #(.DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_src(input int i, input logic [5:0] a, input logic [31:0] d);
        bus.src_addr[6*i +: 6]   = a;
        bus.src_data[32*i +: 32] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.src_valid = 3'b000;
        step();
        rst = 1'b0;
    endtask

    initial begin
        bus.src_valid = '0;
        bus.src_addr  = '0;
        bus.src_data  = '0;

        // Reset state
        step();
        step();
        check("rst_pending", 32'(bus.pending), 0);
        check("rst_we1", 32'(bus.we1), 0);
        check("rst_we2", 32'(bus.we2), 0);
        check("rst_aw1", 32'(bus.aw1), 0);
        check("rst_wd2", bus.wd2, 0);
        check("rst_ready", 32'(bus.src_ready), 32'h7);
        rst = 1'b0;

        // Single ALU beat, write two edges after the push
        set_src(0, 6'd5, 32'h1234_5678);
        bus.src_valid = 3'b001;
        step();
        bus.src_valid = 3'b000;
        check("single_pend1", 32'(bus.pending), 1);
        check("single_we1_early", 32'(bus.we1), 0);
        step();
        check("single_we1", 32'(bus.we1), 1);
        check("single_aw1", 32'(bus.aw1), 5);
        check("single_wd1", bus.wd1, 32'h1234_5678);
        check("single_we2", 32'(bus.we2), 0);
        check("single_pend0", 32'(bus.pending), 0);
        step();
        check("idle_we1", 32'(bus.we1), 0);
        check("idle_aw1_hold", 32'(bus.aw1), 5);
        check("idle_wd1_hold", bus.wd1, 32'h1234_5678);

        // Dual grant from rr=0, then rr=2 proven by a three-way contention
        do_reset();
        set_src(0, 6'd3, 32'hAAAA_0001);
        set_src(1, 6'd4, 32'hFFFF_0001);
        bus.src_valid = 3'b011;
        step();
        bus.src_valid = 3'b000;
        step();
        check("dual_we1", 32'(bus.we1), 1);
        check("dual_aw1", 32'(bus.aw1), 3);
        check("dual_wd1", bus.wd1, 32'hAAAA_0001);
        check("dual_we2", 32'(bus.we2), 1);
        check("dual_aw2", 32'(bus.aw2), 4);
        check("dual_wd2", bus.wd2, 32'hFFFF_0001);
        set_src(0, 6'd10, 32'hA2);
        set_src(1, 6'd11, 32'hF2);
        set_src(2, 6'd12, 32'hC2);
        bus.src_valid = 3'b111;
        step();
        bus.src_valid = 3'b000;
        check("tri_pend3", 32'(bus.pending), 3);
        step();
        check("tri_aw1_load", 32'(bus.aw1), 12);
        check("tri_aw2_alu", 32'(bus.aw2), 10);
        check("tri_pend1", 32'(bus.pending), 1);
        step();
        check("tri_aw1_fpu", 32'(bus.aw1), 11);
        check("tri_we1_fpu", 32'(bus.we1), 1);
        check("tri_we2_off", 32'(bus.we2), 0);
        check("tri_pend0", 32'(bus.pending), 0);

        // Same-address collision: port 2 suppressed, loser writes next cycle
        do_reset();
        set_src(0, 6'd7, 32'hD0);
        set_src(2, 6'd7, 32'hD2);
        bus.src_valid = 3'b101;
        step();
        bus.src_valid = 3'b000;
        step();
        check("coll_k_we1", 32'(bus.we1), 1);
        check("coll_k_wd1", bus.wd1, 32'hD0);
        check("coll_k_we2", 32'(bus.we2), 0);
        check("coll_k_pend", 32'(bus.pending), 1);
        step();
        check("coll_k1_we1", 32'(bus.we1), 1);
        check("coll_k1_aw1", 32'(bus.aw1), 7);
        check("coll_k1_wd1", bus.wd1, 32'hD2);
        check("coll_k1_we2", 32'(bus.we2), 0);

        // Backpressure: ALU and FPU streaming to one register, FPU fills after two accepts
        do_reset();
        set_src(0, 6'd9, 32'hA0);
        set_src(1, 6'd9, 32'hF0);
        bus.src_valid = 3'b011;
        step();
        check("bp_e0_pend", 32'(bus.pending), 2);
        check("bp_e0_ready", 32'(bus.src_ready), 32'h7);
        set_src(0, 6'd9, 32'hA1);
        set_src(1, 6'd9, 32'hF1);
        step();
        check("bp_e1_ready", 32'(bus.src_ready), 32'h5);
        check("bp_e1_pend", 32'(bus.pending), 3);
        check("bp_e1_wd1", bus.wd1, 32'hA0);
        check("bp_e1_we2", 32'(bus.we2), 0);
        set_src(0, 6'd9, 32'hA2);
        set_src(1, 6'd9, 32'hF2);
        step();
        check("bp_e2_ready", 32'(bus.src_ready), 32'h6);
        check("bp_e2_wd1", bus.wd1, 32'hF0);
        set_src(0, 6'd9, 32'hA3);
        set_src(1, 6'd9, 32'hF3);
        step();
        bus.src_valid = 3'b000;
        check("bp_e3_ready", 32'(bus.src_ready), 32'h5);
        check("bp_e3_wd1", bus.wd1, 32'hA1);
        step();
        check("bp_e4_wd1", bus.wd1, 32'hF1);
        check("bp_e4_pend", 32'(bus.pending), 2);
        step();
        check("bp_e5_wd1", bus.wd1, 32'hA2);
        step();
        check("bp_e6_wd1", bus.wd1, 32'hF3);
        check("bp_e6_pend", 32'(bus.pending), 0);

        // Address-0 beat is consumed without a write
        set_src(0, 6'd0, 32'hDEAD_BEEF);
        bus.src_valid = 3'b001;
        step();
        bus.src_valid = 3'b000;
        check("a0_pend1", 32'(bus.pending), 1);
        step();
        check("a0_we1", 32'(bus.we1), 0);
        check("a0_we2", 32'(bus.we2), 0);
        check("a0_pend0", 32'(bus.pending), 0);

        // Fill, then reset mid-operation discards everything
        set_src(0, 6'd1, 32'h11);
        set_src(1, 6'd2, 32'h22);
        set_src(2, 6'd3, 32'h33);
        bus.src_valid = 3'b111;
        step();
        step();
        step();
        check("fill_pend4", 32'(bus.pending), 4);
        do_reset();
        #1;
        check("mrst_pending", 32'(bus.pending), 0);
        check("mrst_we1", 32'(bus.we1), 0);
        check("mrst_we2", 32'(bus.we2), 0);
        check("mrst_ready", 32'(bus.src_ready), 32'h7);
        step();
        check("post_we1", 32'(bus.we1), 0);
        check("post_we2", 32'(bus.we2), 0);
        check("post_pending", 32'(bus.pending), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, per-source result FIFO depth, legal values 2 or 4.
REQ-002 The block SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 The block SHALL have port rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 The block SHALL have port src_valid  input  3  result valid per source; bit0 ALU, bit1 FPU, bit2 load unit.
REQ-005 The block SHALL have port src_ready  output  3  per-source accept.
REQ-006 The block SHALL have port src_addr  input  18  destination register per source; 6 bits each, source i at [6i+5:6i].
REQ-007 The block SHALL have port src_data  input  96  result data per source; 32 bits each, source i at [32i+31:32i].
REQ-008 The block SHALL have port we1  output  1  register file write enable, port 1.
REQ-009 The block SHALL have port aw1  output  6  write address, port 1.
REQ-010 The block SHALL have port wd1  output  32  write data, port 1.
REQ-011 The block SHALL have ports we2, aw2 and wd2  output  1/6/32  same as port 1; on same-address collision in the register file, port 2 wins.
REQ-012 The block SHALL have port pending  output  4  total entries held across all FIFOs.

Function
REQ-013 The block SHALL accept a source beat when src_valid[i] and src_ready[i] are both high at posedge; the beat is pushed into FIFO i.
REQ-014 The block SHALL drive src_ready[i] from registered state only, as (count_i < DEPTH); there is no same-cycle pop-through when full.
REQ-015 The block SHALL consider only FIFO heads for arbitration; at most one entry per source per cycle.
REQ-016 The block SHALL keep a round-robin pointer rr in 0..2; scan order is rr, rr+1, rr+2 mod 3.
REQ-017 The block SHALL grant port 1 to the first non-empty head in scan order, and port 2 to the next non-empty head in scan order.
REQ-018 If the port-2 candidate has the same addr as the port-1 grant, the block SHALL NOT grant port 2 that cycle; the candidate stays at its head.
REQ-019 The block SHALL pop granted heads in the grant cycle, and register the outputs we/aw/wd so that the write appears one cycle after the grant (push at N -> earliest write at N+2: grant at N+1, outputs valid N+2).
REQ-020 A granted head with addr 0 SHALL be popped and consume its port, with the corresponding we held low.
REQ-021 If no entry is granted on a port, the block SHALL drive that port's we low, with aw and wd holding their previous values.
REQ-022 After any grant, the block SHALL set rr to (index of the last granted source + 1) mod 3; with no grant, rr is unchanged.
REQ-023 Push and pop on the same FIFO in the same cycle SHALL be allowed when count < DEPTH; the count is then unchanged.
REQ-024 pending SHALL equal the sum of the three FIFO counts, registered, updated the same edge as the counts.
REQ-025 Each FIFO SHALL preserve order per source; read and write pointers wrap modulo DEPTH.

Reset
REQ-026 While rst is high at posedge, the block SHALL clear all FIFO counts and pointers, rr=0, we1=we2=0, aw1=aw2=0, wd1=wd2=0 and pending=0.
REQ-027 rst asserted mid-operation SHALL discard all buffered entries; no write is issued on the cycle after reset.
REQ-028 src_ready SHALL be 3'b111 on the first cycle after reset deasserts.

Verification
REQ-029 Single ALU beat: addr 5, data 0x12345678 at cycle N -> we1=1, aw1=5, wd1=0x12345678 at N+2; we2=0.
REQ-030 Simultaneous ALU addr 3 and FPU addr 4, rr=0 -> same cycle: port1 = ALU (aw1=3), port2 = FPU (aw2=4); rr becomes 2.
REQ-031 ALU and load both addr 7, rr=0 -> cycle k: only port1 writes the ALU data; cycle k+1: port1 writes the load data; we2=0 both cycles.
REQ-032 FPU held valid with no grants (DEPTH=2) -> src_ready[1] drops after 2 accepts, pending=2, and a third beat is not accepted until a pop.
REQ-033 ALU beat with addr 0 -> popped, we1=0, pending returns to 0.
REQ-034 Fill all FIFOs, then assert rst for one cycle -> pending=0, we1=we2=0, src_ready=3'b111 the following cycle.
